// File: rtl/packet_assembler_buffered_if.sv
// ---------------------------------------------------------------------------
// packet_assembler_buffered_if
//
// Purpose : valid/ready packet source bus feeding the buffered data-island
//           packet assembler. One beat carries a whole packet: the 24-bit
//           header plus NUM_SUB subpacket payloads.
//
// Signals :
//   pkt_valid  source offers a packet this cycle
//   pkt_ready  assembler's holding buffer can take a packet this cycle
//   header     24-bit packet header
//   sub        NUM_SUB subpacket payloads, SUB_BITS = 32*LANES-8 bits each
//
// Modports: master = packet source, slave = packet_assembler_buffered.
// ---------------------------------------------------------------------------
interface packet_assembler_buffered_if #(
    parameter int NUM_SUB = 4,
    parameter int LANES   = 2
);
    localparam int SUB_BITS = 32 * LANES - 8;

    logic                pkt_valid;
    logic                pkt_ready;
    logic [23:0]         header;
    logic [SUB_BITS-1:0] sub [NUM_SUB];

    modport master (
        output pkt_valid,
        output header,
        output sub,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  header,
        input  sub,
        output pkt_ready
    );
endinterface

// File: rtl/packet_assembler_buffered.sv
// ---------------------------------------------------------------------------
// packet_assembler_buffered
//
// Purpose : accepts whole data-island packets into a one-entry holding
//           buffer, moves them into a current-packet register at packet
//           boundaries, and serialises the current packet over 32 slots with
//           BCH(64,56)/(32,24) style ECC appended. When nothing is pending a
//           null packet (all zeros) is sent.
//
// Ports   :
//   clk_pixel           pixel clock, the only clock
//   reset_n             synchronous active-low reset
//   data_island_period  high while data-island slots are transmitted
//   pkt_if              slave side of the packet valid/ready bus
//   packet_data         OUT_W bits for the current slot
//   counter             slot index 0..31
//   pkt_done            one-cycle pulse after a real packet's last slot
//   aborted             one-cycle pulse after an island was cut short
// ---------------------------------------------------------------------------
module packet_assembler_buffered #(
    parameter  int NUM_SUB  = 4,
    parameter  int LANES    = 2,
    localparam int SUB_BITS = 32 * LANES - 8,
    localparam int OUT_W    = 1 + NUM_SUB * LANES
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic                 data_island_period,
    packet_assembler_buffered_if.slave pkt_if,
    output logic [OUT_W-1:0]     packet_data,
    output logic [4:0]           counter,
    output logic                 pkt_done,
    output logic                 aborted
);

    localparam int         BLK_BITS = 32 * LANES;
    localparam int         IDX_W    = $clog2(BLK_BITS);
    // Subpacket data occupies slots below this index; the rest carry parity.
    localparam logic [4:0] SUB_LAST = 5'(32 - 8 / LANES);
    localparam logic [7:0] POLY     = 8'h83;

    // One bit of the BCH parity LFSR.
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? POLY : 8'h00);
    endfunction

    // LANES bits per clock, lowest bit index first.
    function automatic logic [7:0] ecc_lanes(input logic [7:0] e_in, input logic [LANES-1:0] bits);
        logic [7:0] e;
        e = e_in;
        for (int j = 0; j < LANES; j++) begin
            e = ecc_step(e, bits[j]);
        end
        return e;
    endfunction

    logic                dip;
    logic                at_last;
    logic                abort;
    logic                hold_drain;
    logic                xfer;

    logic                rdy_en_q,      rdy_en_d;
    logic                hold_full_q,   hold_full_d;
    logic [23:0]         hold_header_q, hold_header_d;
    logic [SUB_BITS-1:0] hold_sub_q [NUM_SUB];
    logic [SUB_BITS-1:0] hold_sub_d [NUM_SUB];
    logic                cur_valid_q,   cur_valid_d;
    logic [23:0]         cur_header_q,  cur_header_d;
    logic [SUB_BITS-1:0] cur_sub_q [NUM_SUB];
    logic [SUB_BITS-1:0] cur_sub_d [NUM_SUB];
    logic [4:0]          counter_q,     counter_d;
    logic [7:0]          par_hdr_q,     par_hdr_d;
    logic [7:0]          par_sub_q [NUM_SUB];
    logic [7:0]          par_sub_d [NUM_SUB];
    logic                pkt_done_q,    pkt_done_d;
    logic                aborted_q,     aborted_d;

    logic [31:0]         hdr_bch;
    logic                hdr_bit;
    logic [IDX_W-1:0]    lane_base;
    logic [BLK_BITS-1:0] sub_bch  [NUM_SUB];
    logic [LANES-1:0]    sub_lane [NUM_SUB];

    // Control decodes shared by the buffer, current register and ECC.
    // A drain happens at a packet boundary: the island wrap, or while idle
    // with nothing current. Dropping dip mid-island is an abort.
    always_comb begin
        dip        = data_island_period;
        at_last    = (counter_q == 5'd31);
        abort      = !dip && (counter_q != 5'd0);
        hold_drain = hold_full_q && ((dip && at_last) || (!dip && !cur_valid_q));
        xfer       = pkt_if.pkt_valid && pkt_if.pkt_ready;
    end

    // rdy_en_q keeps pkt_ready low through reset and for the first edge after.
    assign pkt_if.pkt_ready = rdy_en_q && (!hold_full_q || hold_drain);

    // Holding buffer: a new transfer wins over a drain, so a simultaneous
    // drain and refill leaves the buffer full with the new packet.
    always_comb begin
        rdy_en_d      = 1'b1;
        hold_full_d   = hold_full_q;
        hold_header_d = hold_header_q;
        hold_sub_d    = hold_sub_q;
        if (xfer) begin
            hold_full_d   = 1'b1;
            hold_header_d = pkt_if.header;
            hold_sub_d    = pkt_if.sub;
        end else if (hold_drain) begin
            hold_full_d = 1'b0;
        end
    end

    // Current packet: emptied at the island wrap or on abort, then refilled
    // from the buffer if a drain is due. Loading after the abort clear means
    // the held packet replaces a dropped one rather than being lost.
    always_comb begin
        cur_valid_d  = cur_valid_q;
        cur_header_d = cur_header_q;
        cur_sub_d    = cur_sub_q;
        if (abort || (dip && at_last)) begin
            cur_valid_d = 1'b0;
        end
        if (hold_drain) begin
            cur_valid_d  = 1'b1;
            cur_header_d = hold_header_q;
            cur_sub_d    = hold_sub_q;
        end
    end

    // Slot selection. Each block is {parity, data}; the slot index picks one
    // header bit and LANES consecutive bits of every subpacket block.
    always_comb begin
        hdr_bch   = {par_hdr_q, cur_header_q};
        hdr_bit   = hdr_bch[counter_q];
        lane_base = IDX_W'(counter_q) * IDX_W'(LANES);
        for (int i = 0; i < NUM_SUB; i++) begin
            sub_bch[i]  = {par_sub_q[i], cur_sub_q[i]};
            sub_lane[i] = sub_bch[i][lane_base +: LANES];
        end
    end

    // Slot counter and ECC accumulation. Parity only advances across the
    // data slots; once frozen, the slot selection above shifts it out.
    always_comb begin
        counter_d = dip ? counter_q + 5'd1 : 5'd0;
        par_hdr_d = par_hdr_q;
        par_sub_d = par_sub_q;
        if (!dip || at_last) begin
            par_hdr_d = 8'h00;
            for (int i = 0; i < NUM_SUB; i++) begin
                par_sub_d[i] = 8'h00;
            end
        end else begin
            if (counter_q < 5'd24) begin
                par_hdr_d = ecc_step(par_hdr_q, hdr_bit);
            end
            if (counter_q < SUB_LAST) begin
                for (int i = 0; i < NUM_SUB; i++) begin
                    par_sub_d[i] = ecc_lanes(par_sub_q[i], sub_lane[i]);
                end
            end
        end
    end

    // Status pulses, registered so they appear in the cycle after the event.
    always_comb begin
        pkt_done_d = dip && at_last && cur_valid_q;
        aborted_d  = abort;
    end

    // Output word: header bit in bit 0, then lane-major subpacket bits.
    // A null packet forces every bit to zero.
    always_comb begin
        packet_data = '0;
        if (cur_valid_q) begin
            packet_data[0] = hdr_bit;
            for (int j = 0; j < LANES; j++) begin
                for (int i = 0; i < NUM_SUB; i++) begin
                    packet_data[1 + j * NUM_SUB + i] = sub_lane[i][j];
                end
            end
        end
    end

    assign counter  = counter_q;
    assign pkt_done = pkt_done_q;
    assign aborted  = aborted_q;

    // State register. Reset empties both entries and suppresses all pulses.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            rdy_en_q      <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_header_q <= '0;
            cur_valid_q   <= 1'b0;
            cur_header_q  <= '0;
            counter_q     <= 5'd0;
            par_hdr_q     <= 8'h00;
            pkt_done_q    <= 1'b0;
            aborted_q     <= 1'b0;
            for (int i = 0; i < NUM_SUB; i++) begin
                hold_sub_q[i] <= '0;
                cur_sub_q[i]  <= '0;
                par_sub_q[i]  <= 8'h00;
            end
        end else begin
            rdy_en_q      <= rdy_en_d;
            hold_full_q   <= hold_full_d;
            hold_header_q <= hold_header_d;
            cur_valid_q   <= cur_valid_d;
            cur_header_q  <= cur_header_d;
            counter_q     <= counter_d;
            par_hdr_q     <= par_hdr_d;
            pkt_done_q    <= pkt_done_d;
            aborted_q     <= aborted_d;
            for (int i = 0; i < NUM_SUB; i++) begin
                hold_sub_q[i] <= hold_sub_d[i];
                cur_sub_q[i]  <= cur_sub_d[i];
                par_sub_q[i]  <= par_sub_d[i];
            end
        end
    end

endmodule

// File: tb/tb_packet_assembler_buffered.sv
// ---------------------------------------------------------------------------
// tb_packet_assembler_buffered
//
// Purpose : directed bench for packet_assembler_buffered. Instance u_dut1 is
//           the default build (NUM_SUB=4, LANES=2); u_dut2 is NUM_SUB=2,
//           LANES=1 and is held in reset until its own phase.
// ---------------------------------------------------------------------------
module tb_packet_assembler_buffered;

    typedef struct packed {
        logic [23:0]      h;
        logic [3:0][55:0] s;
    } pkt_t;

    logic       clk_pixel = 1'b0;
    logic       reset1_n;
    logic       reset2_n;
    logic       dip1;
    logic       dip2;
    logic [8:0] pd1;
    logic [2:0] pd2;
    logic [4:0] cnt1;
    logic [4:0] cnt2;
    logic       done1;
    logic       done2;
    logic       abrt1;
    logic       abrt2;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] trace0;
    logic [31:0] trace1;
    logic        sub_or;
    pkt_t        q1[$];
    pkt_t        q2[$];
    pkt_t        nul;
    pkt_t        p1, p2, p3, p4, p5, p6, p7, p8;
    pkt_t        r1, r2, r3;

    packet_assembler_buffered_if #(.NUM_SUB(4), .LANES(2)) bus1();
    packet_assembler_buffered_if #(.NUM_SUB(2), .LANES(1)) bus2();

    packet_assembler_buffered #(.NUM_SUB(4), .LANES(2)) u_dut1 (
        .clk_pixel          (clk_pixel),
        .reset_n            (reset1_n),
        .data_island_period (dip1),
        .pkt_if             (bus1),
        .packet_data        (pd1),
        .counter            (cnt1),
        .pkt_done           (done1),
        .aborted            (abrt1)
    );

    packet_assembler_buffered #(.NUM_SUB(2), .LANES(1)) u_dut2 (
        .clk_pixel          (clk_pixel),
        .reset_n            (reset2_n),
        .data_island_period (dip2),
        .pkt_if             (bus2),
        .packet_data        (pd2),
        .counter            (cnt2),
        .pkt_done           (done2),
        .aborted            (abrt2)
    );

    // Free-running pixel clock, 10 time units per cycle.
    always #5 clk_pixel = ~clk_pixel;

    function automatic pkt_t mk(input logic [23:0] h, input logic [55:0] s0,
                                input logic [55:0] s1, input logic [55:0] s2,
                                input logic [55:0] s3);
        pkt_t p;
        p.h    = h;
        p.s[0] = s0;
        p.s[1] = s1;
        p.s[2] = s2;
        p.s[3] = s3;
        return p;
    endfunction

    // Bit-serial BCH parity over the first n bits of d.
    function automatic logic [7:0] ecc(input logic [63:0] d, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (e[0] ^ d[k]) e = (e >> 1) ^ 8'h83;
            else             e = e >> 1;
        end
        return e;
    endfunction

    // Expected slot word for a packet transmitted in full.
    function automatic logic [8:0] exp_slot(input pkt_t p, input bit v, input int c,
                                            input int ns, input int ln);
        logic [8:0]  r;
        logic [31:0] hb;
        logic [63:0] blk;
        logic [7:0]  e;
        int          sb;
        r = '0;
        if (!v) return r;
        hb   = {ecc(64'(p.h), 24), p.h};
        r[0] = hb[c];
        sb   = 32 * ln - 8;
        for (int i = 0; i < ns; i++) begin
            blk = '0;
            for (int k = 0; k < sb; k++) blk[k] = p.s[i][k];
            e = ecc(blk, sb);
            for (int k = 0; k < 8; k++) blk[sb + k] = e[k];
            for (int j = 0; j < ln; j++) r[1 + j * ns + i] = blk[c * ln + j];
        end
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    // Present the head of each offer queue, or drop valid when empty.
    task automatic apply_stimulus();
        if (q1.size() > 0) begin
            bus1.pkt_valid = 1'b1;
            bus1.header    = q1[0].h;
            for (int i = 0; i < 4; i++) bus1.sub[i] = q1[0].s[i];
        end else begin
            bus1.pkt_valid = 1'b0;
        end
        if (q2.size() > 0) begin
            bus2.pkt_valid = 1'b1;
            bus2.header    = q2[0].h;
            for (int i = 0; i < 2; i++) bus2.sub[i] = q2[0].s[i][23:0];
        end else begin
            bus2.pkt_valid = 1'b0;
        end
    endtask

    // One clock: note handshakes before the edge, retire accepted packets.
    task automatic step();
        bit f1;
        bit f2;
        #1;
        f1 = bus1.pkt_valid && bus1.pkt_ready;
        f2 = bus2.pkt_valid && bus2.pkt_ready;
        @(posedge clk_pixel);
        #1;
        if (f1) void'(q1.pop_front());
        if (f2) void'(q2.pop_front());
        apply_stimulus();
        #1;
    endtask

    // Check slots c0..c1-1 of an island on one instance against the model.
    task automatic run_slots(input int which, input pkt_t p, input bit v,
                             input int c0, input int c1);
        for (int c = c0; c < c1; c++) begin
            logic [8:0] e;
            logic [8:0] o;
            e = (which == 1) ? exp_slot(p, v, c, 4, 2) : exp_slot(p, v, c, 2, 1);
            o = (which == 1) ? pd1 : {6'b0, pd2};
            trace0[c] = o[0];
            trace1[c] = o[1];
            sub_or    = sub_or | (|o[8:1]);
            check_output($sformatf("d%0d_data_c%0d", which, c), 32'(o), 32'(e));
            check_output($sformatf("d%0d_counter_c%0d", which, c),
                         32'((which == 1) ? cnt1 : cnt2), 32'(c));
            step();
            check_output($sformatf("d%0d_done_after_c%0d", which, c),
                         32'((which == 1) ? done1 : done2), 32'((c == 31) && v));
        end
    endtask

    initial begin
        reset1_n       = 1'b0;
        reset2_n       = 1'b0;
        dip1           = 1'b0;
        dip2           = 1'b0;
        bus1.pkt_valid = 1'b0;
        bus1.header    = '0;
        bus2.pkt_valid = 1'b0;
        bus2.header    = '0;
        for (int i = 0; i < 4; i++) bus1.sub[i] = '0;
        for (int i = 0; i < 2; i++) bus2.sub[i] = '0;
        trace0 = '0;
        trace1 = '0;
        sub_or = 1'b0;

        nul = mk(24'h0, 56'h0, 56'h0, 56'h0, 56'h0);
        p1  = mk(24'h123457, 56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00000000000001, 56'h80000000000000);
        p2  = mk(24'hABCDE0, 56'h55555555555555, 56'hAAAAAAAAAAAAAA, 56'h0F0F0F0F0F0F0F, 56'hF0F0F0F0F0F0F0);
        p3  = mk(24'h5A5A5B, 56'h00000000FFFFFF, 56'hFFFFFF00000000, 56'h13579BDF2468AC, 56'hC0FFEE00BADF00);
        p4  = mk(24'h000F00, 56'h11111111111111, 56'h22222222222222, 56'h33333333333333, 56'h44444444444444);
        p5  = mk(24'h7E7E7E, 56'hDEADBEEFCAFE01, 56'h0, 56'h0, 56'hFFFFFFFFFFFFFF);
        p6  = mk(24'h8001FF, 56'h1, 56'h2, 56'h4, 56'h8);
        p7  = mk(24'h246801, 56'hABABABABABABAB, 56'hCDCDCDCDCDCDCD, 56'hEFEFEFEFEFEFEF, 56'h01010101010101);
        p8  = mk(24'h999999, 56'h77777777777777, 56'h88888888888888, 56'h99999999999999, 56'h66666666666666);
        r1  = mk(24'h000000, 56'h1, 56'h0, 56'h0, 56'h0);
        r2  = mk(24'hC0FFEE, 56'h123456, 56'hABCDEF, 56'h0, 56'h0);
        r3  = mk(24'h0F1E2D, 56'h800001, 56'h3C3C3C, 56'h0, 56'h0);

        // Reset state of the default build.
        $display("[TB] reset and first single-bit packet");
        step();
        step();
        check_output("rst_counter", 32'(cnt1), 32'd0);
        check_output("rst_ready",   32'(bus1.pkt_ready), 32'd0);
        check_output("rst_data",    32'(pd1), 32'd0);
        check_output("rst_done",    32'(done1), 32'd0);
        check_output("rst_aborted", 32'(abrt1), 32'd0);
        reset1_n = 1'b1;
        step();
        check_output("ready_after_rst", 32'(bus1.pkt_ready), 32'd1);

        // Header 000001 with zero subpackets: known ECC 8'h4A.
        q1.push_back(mk(24'h000001, 56'h0, 56'h0, 56'h0, 56'h0));
        apply_stimulus();
        step();
        step();
        check_output("idle_counter", 32'(cnt1), 32'd0);
        dip1   = 1'b1;
        trace0 = '0;
        sub_or = 1'b0;
        run_slots(1, mk(24'h000001, 56'h0, 56'h0, 56'h0, 56'h0), 1'b1, 0, 32);
        check_output("hdr_bit0_trace", trace0, 32'h4A000001);
        check_output("sub_bits_zero",  32'(sub_or), 32'd0);

        // Nothing pending: null island.
        $display("[TB] null island");
        run_slots(1, nul, 1'b0, 0, 32);

        // Back-to-back: P1 waits in hold, P2 follows, P3 is held off.
        $display("[TB] back-to-back packets");
        q1.push_back(p1);
        q1.push_back(p2);
        q1.push_back(p3);
        apply_stimulus();
        run_slots(1, nul, 1'b0, 0, 32);
        run_slots(1, p1, 1'b1, 0, 11);
        check_output("b2b_ready_held_off", 32'(bus1.pkt_ready), 32'd0);
        check_output("b2b_still_waiting",  32'(q1.size()), 32'd1);
        run_slots(1, p1, 1'b1, 11, 32);
        run_slots(1, p2, 1'b1, 0, 32);
        run_slots(1, p3, 1'b1, 0, 32);

        // Inputs change after acceptance; transmitted packet must not.
        $display("[TB] source changes mid-packet");
        dip1 = 1'b0;
        q1.push_back(p4);
        apply_stimulus();
        step();
        step();
        check_output("load_counter", 32'(cnt1), 32'd0);
        check_output("load_aborted", 32'(abrt1), 32'd0);
        check_output("load_ready",   32'(bus1.pkt_ready), 32'd1);
        dip1 = 1'b1;
        run_slots(1, p4, 1'b1, 0, 5);
        bus1.header = 24'hFFFFFF;
        for (int i = 0; i < 4; i++) bus1.sub[i] = {56{1'b1}};
        run_slots(1, p4, 1'b1, 5, 20);
        q1.push_back(p5);
        apply_stimulus();
        run_slots(1, p4, 1'b1, 20, 32);

        // Abort P5 at slot 10 with P6 waiting; P6 goes next.
        $display("[TB] abort mid-packet");
        q1.push_back(p6);
        apply_stimulus();
        run_slots(1, p5, 1'b1, 0, 10);
        dip1 = 1'b0;
        step();
        check_output("abort_counter", 32'(cnt1), 32'd0);
        check_output("abort_pulse",   32'(abrt1), 32'd1);
        check_output("abort_no_done", 32'(done1), 32'd0);
        step();
        check_output("abort_pulse_end", 32'(abrt1), 32'd0);
        check_output("abort_idle_cnt",  32'(cnt1), 32'd0);
        dip1 = 1'b1;
        run_slots(1, p6, 1'b1, 0, 32);

        // Reset at slot 20 with hold full: both entries discarded.
        $display("[TB] reset mid-packet, default build");
        q1.push_back(p7);
        q1.push_back(p8);
        apply_stimulus();
        run_slots(1, nul, 1'b0, 0, 32);
        run_slots(1, p7, 1'b1, 0, 20);
        reset1_n = 1'b0;
        step();
        check_output("mrst_counter", 32'(cnt1), 32'd0);
        check_output("mrst_ready",   32'(bus1.pkt_ready), 32'd0);
        check_output("mrst_data",    32'(pd1), 32'd0);
        check_output("mrst_done",    32'(done1), 32'd0);
        check_output("mrst_aborted", 32'(abrt1), 32'd0);
        step();
        check_output("mrst_ready_2", 32'(bus1.pkt_ready), 32'd0);
        reset1_n = 1'b1;
        run_slots(1, nul, 1'b0, 0, 32);
        check_output("mrst_ready_back", 32'(bus1.pkt_ready), 32'd1);

        // NUM_SUB=2, LANES=1 build: subpackets follow header-style ECC.
        $display("[TB] NUM_SUB=2 LANES=1 build");
        check_output("d2_rst_counter", 32'(cnt2), 32'd0);
        check_output("d2_rst_ready",   32'(bus2.pkt_ready), 32'd0);
        check_output("d2_rst_data",    32'(pd2), 32'd0);
        reset2_n = 1'b1;
        step();
        check_output("d2_ready_after_rst", 32'(bus2.pkt_ready), 32'd1);
        q2.push_back(r1);
        apply_stimulus();
        step();
        step();
        dip2   = 1'b1;
        trace0 = '0;
        trace1 = '0;
        run_slots(2, r1, 1'b1, 0, 32);
        check_output("d2_hdr_trace",  trace0, 32'h00000000);
        check_output("d2_sub0_trace", trace1, 32'h4A000001);

        q2.push_back(r2);
        q2.push_back(r3);
        apply_stimulus();
        run_slots(2, nul, 1'b0, 0, 32);
        run_slots(2, r2, 1'b1, 0, 20);
        reset2_n = 1'b0;
        step();
        check_output("d2_mrst_counter", 32'(cnt2), 32'd0);
        check_output("d2_mrst_ready",   32'(bus2.pkt_ready), 32'd0);
        check_output("d2_mrst_data",    32'(pd2), 32'd0);
        check_output("d2_mrst_done",    32'(done2), 32'd0);
        reset2_n = 1'b1;
        run_slots(2, nul, 1'b0, 0, 32);
        check_output("d2_mrst_ready_back", 32'(bus2.pkt_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
